npc_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC core. Steps each instruction through fetch, decode, execute, memory and writeback.
- Gates the decoder's write enables so that the register file, data memory and PC each update exactly once per instruction.
- Sits between the instruction-fetch port, the control-signal decoder outputs and the LSU handshake. Counts retired instructions and stops the core on ebreak, illegal instruction or bus timeout.

---
 rtl/npc_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_npc_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for NPC.
// Gates decoder write enables so RF, DMEM and PC update once per insn.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   ifu_req          fetch request (high in FETCH)
//   ifu_rvalid       fetch data valid
//   ifu_rdata        fetched instruction word
//   inst             latched instruction register (to decoder)
//   dec_regwr        decoder RegWr
//   dec_memtoreg     decoder MemtoReg (load)
//   dec_memwr        decoder MemWr (store)
//   dec_ebreak       decoded ebreak
//   dec_illegal      no valid encoding
//   lsu_req          data memory request (high in MEM)
//   lsu_wen          data request is a store
//   lsu_done         data access complete
//   rf_we            register-file write strobe (WB only)
//   pc_we            PC update strobe (WB only)
//   halt             sticky, stopped by ebreak
//   error            sticky, illegal insn or bus timeout
//   state            current state code
//   instret          retired-instruction count

module npc_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_rvalid,
  input  logic [31:0]      ifu_rdata,
  output logic [31:0]      inst,
  input  logic             dec_regwr,
  input  logic             dec_memtoreg,
  input  logic             dec_memwr,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_done,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Wait counter just wide enough to hold TIMEOUT.
  localparam int WW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  state_t        st;
  logic [WW-1:0] wcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      inst    <= '0;
      instret <= '0;
      wcnt    <= '0;
    end else begin
      unique case (st)
        S_IDLE: st <= S_FETCH;
        S_FETCH: begin
          // A response on the last allowed cycle still wins.
          if (ifu_rvalid) begin
            inst <= ifu_rdata;
            wcnt <= '0;
            st   <= S_DECODE;
          end else if (wcnt == WMAX) begin
            wcnt <= '0;
            st   <= S_ERROR;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_DECODE: begin
          if (dec_illegal)
            st <= S_ERROR;
          else if (dec_ebreak)
            st <= S_HALT;
          else
            st <= S_EXEC;
        end
        S_EXEC: begin
          if (dec_memtoreg || dec_memwr)
            st <= S_MEM;
          else
            st <= S_WB;
        end
        S_MEM: begin
          if (lsu_done) begin
            wcnt <= '0;
            st   <= S_WB;
          end else if (wcnt == WMAX) begin
            wcnt <= '0;
            st   <= S_ERROR;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_WB: begin
          instret <= instret + CNT_W'(1);
          st      <= S_FETCH;
        end
        S_HALT:  st <= S_HALT;
        S_ERROR: st <= S_ERROR;
      endcase
    end
  end

  // Strobes follow the state register directly so an async
  // reset drops them in the same cycle.
  always_comb begin
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    unique case (st)
      S_FETCH: ifu_req = 1'b1;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = dec_memwr;
      end
      S_WB: begin
        pc_we = 1'b1;
        // A store never writes the register file.
        rf_we = dec_regwr & ~dec_memwr;
      end
      default: ;
    endcase
  end

  // HALT and ERROR are absorbing, so these stay set until reset.
  assign halt  = (st == S_HALT);
  assign error = (st == S_ERROR);
  assign state = st;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// tb_npc_seq_ctrl: directed vectors for npc_seq_ctrl.
// Built with CNT_W=4, TIMEOUT=3 to reach wrap and timeout edges.

module tb_npc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        ifu_req;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic        dec_regwr;
  logic        dec_memtoreg;
  logic        dec_memwr;
  logic        dec_ebreak;
  logic        dec_illegal;
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_done;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic        error;
  logic [2:0]  state;
  logic [3:0]  instret;

  int nvec = 0;
  int nbad = 0;
  logic [3:0] exp_ret;

  npc_seq_ctrl #(
    .CNT_W  (4),
    .TIMEOUT(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_req     (ifu_req),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rdata   (ifu_rdata),
    .inst        (inst),
    .dec_regwr   (dec_regwr),
    .dec_memtoreg(dec_memtoreg),
    .dec_memwr   (dec_memwr),
    .dec_ebreak  (dec_ebreak),
    .dec_illegal (dec_illegal),
    .lsu_req     (lsu_req),
    .lsu_wen     (lsu_wen),
    .lsu_done    (lsu_done),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .halt        (halt),
    .error       (error),
    .state       (state),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    ifu_rvalid   = 1'b0;
    ifu_rdata    = 32'h0;
    dec_regwr    = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwr    = 1'b0;
    dec_ebreak   = 1'b0;
    dec_illegal  = 1'b0;
    lsu_done     = 1'b0;
  endtask

  // Enter at a negedge in FETCH. fw = fetch wait cycles,
  // mw_n = MEM wait cycles (-1: no MEM visit).
  task automatic run_insn(input logic [31:0] rd,
                          input int fw,
                          input logic rw,
                          input logic mt,
                          input logic mw,
                          input int mw_n,
                          input logic xwen,
                          input logic xrf);
    ifu_rdata    = rd;
    dec_regwr    = rw;
    dec_memtoreg = mt;
    dec_memwr    = mw;
    dec_ebreak   = 1'b0;
    dec_illegal  = 1'b0;
    ifu_rvalid   = 1'b0;
    for (int i = 0; i < fw; i++) begin
      chk("fetch_wait", {ifu_req, state}, {1'b1, 3'd1});
      step();
    end
    ifu_rvalid = 1'b1;
    chk("fetch", {ifu_req, state}, {1'b1, 3'd1});
    step();
    chk("decode", {rf_we, pc_we, state}, {2'b00, 3'd2});
    chk("inst", inst, rd);
    step();
    chk("exec", {rf_we, pc_we, state}, {2'b00, 3'd3});
    step();
    for (int i = 0; i <= mw_n; i++) begin
      chk("mem",
          {lsu_req, lsu_wen, rf_we, pc_we, state},
          {1'b1, xwen, 2'b00, 3'd4});
      if (i == mw_n) lsu_done = 1'b1;
      step();
    end
    lsu_done = 1'b0;
    chk("wb", {lsu_req, rf_we, pc_we, state},
        {1'b0, xrf, 1'b1, 3'd5});
    exp_ret = exp_ret + 4'd1;
    step();
    chk("retire", {rf_we, pc_we, state, instret},
        {2'b00, 3'd1, exp_ret});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    step();
    chk("rst_state",
        {state, halt, error, ifu_req, instret},
        {3'd0, 3'b000, 4'd0});
    rst = 1'b0;
    step();
    chk("rst_fetch", state, 32'd1);
    exp_ret = 4'd0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    exp_ret = 4'd0;
    step();
    chk("reset",
        {state, inst[15:0], instret},
        {3'd0, 16'h0, 4'd0});
    chk("reset_strb",
        {ifu_req, lsu_req, lsu_wen, rf_we, pc_we, halt, error},
        7'b0);
    chk("reset_inst", inst, 32'h0);
    rst = 1'b0;
    step();
    // addi x1,x0,5: 1,2,3,5,1 after IDLE
    run_insn(32'h00500093, 0, 1'b1, 1'b0, 1'b0, -1,
             1'b0, 1'b1);
    // lw with 3 MEM waits, done lands on the timeout cycle
    run_insn(32'h0000a103, 0, 1'b1, 1'b1, 1'b0, 3,
             1'b0, 1'b1);
    // sw with regwr set: no RF write
    run_insn(32'h0020a023, 0, 1'b1, 1'b0, 1'b1, 0,
             1'b1, 1'b0);
    // memtoreg and memwr both set: treated as store
    run_insn(32'h0020a023, 0, 1'b1, 1'b1, 1'b1, 1,
             1'b1, 1'b0);
    // rvalid arrives on the 4th FETCH cycle: success
    run_insn(32'h00108093, 3, 1'b1, 1'b0, 1'b0, -1,
             1'b0, 1'b1);

    // reset in the middle of MEM
    ifu_rdata    = 32'h0000a103;
    ifu_rvalid   = 1'b1;
    dec_memtoreg = 1'b1;
    dec_regwr    = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_mem", {lsu_req, state}, {1'b1, 3'd4});
    rst = 1'b1;
    #1;
    chk("async_rst",
        {lsu_req, state, instret},
        {1'b0, 3'd0, 4'd0});
    step();
    rst = 1'b0;
    exp_ret = 4'd0;
    step();
    chk("post_rst", state, 32'd1);

    // 16 retirements wrap the 4-bit counter
    for (int k = 0; k < 16; k++)
      run_insn(32'h00108093, 0, 1'b1, 1'b0, 1'b0, -1,
               1'b0, 1'b1);
    chk("wrap", instret, 32'd0);

    // one more so instret is non-zero before ebreak
    run_insn(32'h00108093, 0, 1'b1, 1'b0, 1'b0, -1,
             1'b0, 1'b1);

    // ebreak -> HALT, absorbing, no strobes
    ifu_rdata  = 32'h00100073;
    ifu_rvalid = 1'b1;
    dec_regwr  = 1'b0;
    dec_ebreak = 1'b1;
    step();
    chk("ebrk_dec", state, 32'd2);
    step();
    for (int i = 0; i < 100; i++) begin
      chk("halt",
          {state, halt, error, ifu_req, lsu_req,
           lsu_wen, rf_we, pc_we, instret},
          {3'd6, 1'b1, 1'b0, 5'b0, 4'd1});
      lsu_done  = i[0];
      dec_memwr = i[1];
      dec_regwr = i[0];
      step();
    end

    // illegal beats ebreak -> ERROR
    do_reset();
    ifu_rdata   = 32'hffffffff;
    ifu_rvalid  = 1'b1;
    dec_ebreak  = 1'b1;
    dec_illegal = 1'b1;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("illegal",
          {state, halt, error, ifu_req, lsu_req,
           rf_we, pc_we},
          {3'd7, 1'b0, 1'b1, 4'b0});
      step();
    end

    // MEM timeout: 4 MEM cycles then ERROR
    do_reset();
    ifu_rdata    = 32'h0000a103;
    ifu_rvalid   = 1'b1;
    dec_memtoreg = 1'b1;
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("mem_to_wait", {lsu_req, state}, {1'b1, 3'd4});
      step();
    end
    chk("mem_to_err", {lsu_req, error, state},
        {1'b0, 1'b1, 3'd7});

    // FETCH timeout: 4 FETCH cycles then ERROR
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("fet_to_wait", {ifu_req, state}, {1'b1, 3'd1});
      step();
    end
    chk("fet_to_last", {ifu_req, state}, {1'b1, 3'd1});
    step();
    chk("fet_to_err", {ifu_req, error, state},
        {1'b0, 1'b1, 3'd7});

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
